// File: rtl/aha_wdog_apb_sequencer.sv
// APB master that unlocks, programs, kicks and disables the AHA APB watchdog.
// Optional CFG readback of WDOGLOAD is enabled by defining WDOG_SEQ_READBACK_EN.
module aha_wdog_apb_sequencer #(
   parameter int unsigned PERIOD_W   = 32,
   parameter logic [31:0] CTRL_VAL   = 32'h0000_0003,
   parameter logic [31:0] UNLOCK_KEY = 32'h1ACC_E551
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                START,
   input  logic                STOP,
   input  logic                KICK_REQ,
   input  logic [31:0]         LOAD_VAL,
   input  logic [PERIOD_W-1:0] KICK_PERIOD,
   output logic                BUSY,
   output logic                RUNNING,
   output logic                ERR,
   output logic                PSEL,
   output logic                PENABLE,
   output logic                PWRITE,
   output logic [11:0]         PADDR,
   output logic [31:0]         PWDATA,
   input  logic [31:0]         PRDATA,
   input  logic                PREADY,
   input  logic                PSLVERR
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StCfg  = 3'd1;
   localparam logic [2:0] StRun  = 3'd2;
   localparam logic [2:0] StKick = 3'd3;
   localparam logic [2:0] StDis  = 3'd4;

   localparam logic [11:0] AddrLoad  = 12'h000;
   localparam logic [11:0] AddrCtrl  = 12'h008;
   localparam logic [11:0] AddrClr   = 12'h00C;
   localparam logic [11:0] AddrLock  = 12'hC00;

`ifdef WDOG_SEQ_READBACK_EN
   localparam logic [2:0] CfgLast = 3'd4;
`else
   localparam logic [2:0] CfgLast = 3'd3;
`endif

   logic [2:0]          state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic                access_q, access_d;
   logic [31:0]         load_q, load_d;
   logic [PERIOD_W-1:0] count_q, count_d;
   logic                kick_pend_q, kick_pend_d;
   logic                stop_pend_q, stop_pend_d;
   logic                cfg_fail_q, cfg_fail_d;
   logic                err_q, err_d;

   logic                in_seq;
   logic                done;
   logic                last_op;
   logic                rb_mismatch;
   logic                op_read;
   logic [11:0]         op_addr;
   logic [31:0]         op_data;
   logic [PERIOD_W-1:0] period_last;

   assign in_seq      = (state_q == StCfg) || (state_q == StKick) || (state_q == StDis);
   assign done        = in_seq && access_q && PREADY;
   assign last_op     = (state_q == StCfg) ? (op_q == CfgLast) : (op_q == 3'd2);
   assign period_last = KICK_PERIOD - {{(PERIOD_W-1){1'b0}}, 1'b1};

`ifdef WDOG_SEQ_READBACK_EN
   assign rb_mismatch = done && op_read && (PRDATA != load_q);
`else
   logic unused_prdata;
   assign unused_prdata = ^PRDATA;
   assign rb_mismatch   = 1'b0;
`endif

   // Op decode: every sequence is a list of accesses indexed by op_q.
   always_comb begin
      op_addr = 12'h000;
      op_data = 32'h0;
      op_read = 1'b0;
      case (state_q)
         StCfg: begin
            case (op_q)
               3'd0: begin op_addr = AddrLock; op_data = UNLOCK_KEY; end
               3'd1: begin op_addr = AddrLoad; op_data = load_q;     end
`ifdef WDOG_SEQ_READBACK_EN
               3'd2: begin op_addr = AddrLoad; op_read = 1'b1;       end
               3'd3: begin op_addr = AddrCtrl; op_data = CTRL_VAL;   end
`else
               3'd2: begin op_addr = AddrCtrl; op_data = CTRL_VAL;   end
`endif
               default: begin op_addr = AddrLock; op_data = 32'h0;   end
            endcase
         end
         StKick: begin
            case (op_q)
               3'd0:    begin op_addr = AddrLock; op_data = UNLOCK_KEY; end
               3'd1:    begin op_addr = AddrClr;  op_data = 32'h1;      end
               default: begin op_addr = AddrLock; op_data = 32'h0;      end
            endcase
         end
         StDis: begin
            case (op_q)
               3'd0:    begin op_addr = AddrLock; op_data = UNLOCK_KEY; end
               3'd1:    begin op_addr = AddrCtrl; op_data = 32'h0;      end
               default: begin op_addr = AddrLock; op_data = 32'h0;      end
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      access_d    = access_q;
      load_d      = load_q;
      count_d     = count_q;
      kick_pend_d = kick_pend_q;
      stop_pend_d = stop_pend_q;
      cfg_fail_d  = cfg_fail_q;
      err_d       = done && (PSLVERR || rb_mismatch);

      case (state_q)
         StIdle: begin
            if (START) begin
               state_d    = StCfg;
               op_d       = 3'd0;
               access_d   = 1'b0;
               load_d     = LOAD_VAL;
               cfg_fail_d = 1'b0;
            end
         end
         StRun: begin
            if (STOP) begin
               state_d     = StDis;
               op_d        = 3'd0;
               access_d    = 1'b0;
               kick_pend_d = 1'b0;
            end else if (KICK_REQ || kick_pend_q ||
                         ((KICK_PERIOD != '0) && (count_q == period_last))) begin
               state_d     = StKick;
               op_d        = 3'd0;
               access_d    = 1'b0;
               count_d     = '0;
               kick_pend_d = 1'b0;
            end else begin
               count_d = count_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            if (state_q != StDis) begin
               if (STOP)     stop_pend_d = 1'b1;
               if (KICK_REQ) kick_pend_d = 1'b1;
            end
            if (!access_q) begin
               access_d = 1'b1;
            end else if (PREADY) begin
               access_d = 1'b0;
               if (rb_mismatch) begin
                  // Skip CTRL so the watchdog stays disabled, but still re-lock.
                  op_d       = CfgLast;
                  cfg_fail_d = 1'b1;
               end else if (!last_op) begin
                  op_d = op_q + 3'd1;
               end else begin
                  op_d = 3'd0;
                  if ((state_q == StDis) || cfg_fail_q) begin
                     state_d     = StIdle;
                     kick_pend_d = 1'b0;
                     stop_pend_d = 1'b0;
                  end else if (stop_pend_q || STOP) begin
                     state_d     = StDis;
                     kick_pend_d = 1'b0;
                     stop_pend_d = 1'b0;
                  end else begin
                     state_d = StRun;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= StIdle;
         op_q        <= 3'd0;
         access_q    <= 1'b0;
         load_q      <= 32'h0;
         count_q     <= '0;
         kick_pend_q <= 1'b0;
         stop_pend_q <= 1'b0;
         cfg_fail_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         access_q    <= access_d;
         load_q      <= load_d;
         count_q     <= count_d;
         kick_pend_q <= kick_pend_d;
         stop_pend_q <= stop_pend_d;
         cfg_fail_q  <= cfg_fail_d;
         err_q       <= err_d;
      end
   end

   assign PSEL    = in_seq;
   assign PENABLE = in_seq && access_q;
   assign PWRITE  = in_seq && !op_read;
   assign PADDR   = op_addr;
   assign PWDATA  = op_read ? 32'h0 : op_data;
   assign BUSY    = in_seq;
   assign RUNNING = (state_q == StRun) || (state_q == StKick);
   assign ERR     = err_q;

endmodule
